hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG_AW, default 4, register-address width.
REQ-002 Parameter DEPTH, default 3, number of tracked post-ID stages, slot 0 = EXE … slot DEPTH-1 = WB, legal 2..8.
REQ-003 Parameter FWD_EN, default 1, 1 = forwarding mode, 0 = stall-only mode.
REQ-004 Localparam SW = $clog2(DEPTH+1), forward-select width.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  synchronous, active-low reset.
REQ-007 Port id_valid  in  1  instruction present in ID.
REQ-008 Port id_src1_en / id_src2_en  in  1 each  source operand used.
REQ-009 Port id_src1 / id_src2  in  NREG_AW each  source register numbers.
REQ-010 Port id_wb_en  in  1  ID instruction writes a register.
REQ-011 Port id_dest  in  NREG_AW  destination register.
REQ-012 Port id_mem_r_en  in  1  ID instruction is a load.
REQ-013 Port flush  in  1  branch taken in EXE.
REQ-014 Port mem_stall  in  1  memory stage busy; whole back-end holds.
REQ-015 Port cnt_clr  in  1  clears stall counter.
REQ-016 Port hazard  out  1  freeze IF/ID.
REQ-017 Port fwd_sel1 / fwd_sel2  out  SW each  operand source: 0 = regfile, k+1 = slot k result.
REQ-018 Port stall_cnt  out  16  cycles with hazard asserted.

Function
REQ-019 Scoreboard SHALL hold DEPTH slots, each {valid, wb_en, dest, is_load}.
REQ-020 Match(src, k) SHALL be: src_en & slot[k].valid & slot[k].wb_en & (slot[k].dest == src), for k in 0..DEPTH-2; the WB slot never matches (regfile write-through).
REQ-021 FWD_EN=0: hazard SHALL be id_valid & (any Match on src1 or src2) | mem_stall; fwd_sel SHALL be 0.
REQ-022 FWD_EN=1: hazard SHALL be id_valid & (Match(src,0) & slot[0].is_load, either source) | mem_stall.
REQ-023 FWD_EN=1: fwd_selN SHALL equal k+1 for the lowest (youngest) matching k, else 0; multiple matches resolve to the youngest.
REQ-024 When mem_stall=0, on each rising edge slot[k+1] <= slot[k] for all k, and slot[0] <= ID instruction if id_valid & ~hazard & ~flush, else bubble (valid=0).
REQ-025 When mem_stall=1, all slots SHALL hold, and flush SHALL be ignored (upstream holds the branch).
REQ-026 flush with mem_stall=0 SHALL insert a bubble in slot 0 regardless of hazard; older slots advance normally.
REQ-027 hazard and fwd_sel SHALL be combinational, with zero-cycle latency from ID inputs and slot state.
REQ-028 stall_cnt SHALL increment by 1 on each edge where hazard=1 and saturate at 16'hFFFF.
REQ-029 cnt_clr SHALL zero stall_cnt and take priority over increment in the same cycle.
REQ-030 id_valid=0 SHALL never raise hazard except via mem_stall.

Reset
REQ-031 While rst=0 at a rising edge, all slots SHALL become invalid and stall_cnt SHALL become 0.
REQ-032 While rst=0, hazard and fwd_sel SHALL be driven 0, overriding mem_stall.
REQ-033 Reset mid-operation SHALL discard all in-flight slots, with no residual hazard on the first cycle after release.

Structure
REQ-034 Shared package SHALL hold the slot struct typedef, the FWD_REGFILE=0 constant, and the slot-index-to-select encoding function.
REQ-035 One sub-module, sb_src_match, SHALL compute match vector and youngest-match index for one source; it is instantiated twice.
REQ-036 Slot storage and stall counter SHALL live in the top module; no other state.

Verification
REQ-037 FWD_EN=1: load r3 issued, next ID src1=r3 -> hazard=1 one cycle, stall_cnt=1, then fwd_sel1=2.
REQ-038 FWD_EN=1: ALU writes r5, then next ID reads r5 as src2 -> hazard=0, fwd_sel2=1; one cycle later -> fwd_sel2=2; DEPTH=3 thereafter -> 0.
REQ-039 FWD_EN=0, DEPTH=3: write r2, then read r2 -> hazard=1 for 2 cycles, then 0 with fwd_sel1=0.
REQ-040 flush asserted while ID holds a writer of r7 -> slot 0 bubble; following reader of r7 sees hazard=0, fwd_sel=0.
REQ-041 mem_stall=1 for 3 cycles with a load in slot 0 -> slots frozen, hazard=1, stall_cnt +3; flush during stall ignored.
REQ-042 Drive hazard for 70000 cycles -> stall_cnt=16'hFFFF; cnt_clr with hazard=1 -> 0; rst=0 mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: pipeline slot record and
// forward-select encoding.
package hazard_scoreboard_pkg;

  localparam int unsigned SB_MAX_AW = 16;
  localparam int unsigned SB_MAX_SW = 4;

  typedef logic [SB_MAX_AW-1:0] sb_dest_t;
  typedef logic [SB_MAX_SW-1:0] sb_sel_t;

  typedef struct packed {
    logic     valid;
    logic     wb_en;
    sb_dest_t dest;
    logic     is_load;
  } sb_slot_t;

  localparam sb_sel_t FWD_REGFILE = '0;

  // Slot k forwards as select value k+1; 0 means read the register file.
  function automatic sb_sel_t slot_to_sel(input int unsigned k);
    return sb_sel_t'(k + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-source comparator: match vector against all in-flight slots and the
// select code of the youngest matching slot.
module sb_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                 src_en,
  input  sb_dest_t             src,
  input  sb_slot_t [DEPTH-1:0] slots,
  output logic     [DEPTH-1:0] match,
  output logic                 load_hit,
  output sb_sel_t              sel
);

  logic found;

  always_comb begin
    match = '0;
    found = 1'b0;
    sel   = FWD_REGFILE;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      // The WB slot writes through the register file in the same cycle.
      match[k] = src_en & slots[k].valid & slots[k].wb_en &
                 (slots[k].dest == src) & (k != DEPTH - 1);
      if (match[k] && !found) begin
        sel = slot_to_sel(k);
      end
      found = found | match[k];
    end
  end

  assign load_hit = match[0] & slots[0].is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks post-ID destinations, raises
// the IF/ID freeze and selects operand forwarding sources.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG_AW = 4,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned FWD_EN  = 1,
  localparam int unsigned SW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_src1_en,
  input  logic               id_src2_en,
  input  logic [NREG_AW-1:0] id_src1,
  input  logic [NREG_AW-1:0] id_src2,
  input  logic               id_wb_en,
  input  logic [NREG_AW-1:0] id_dest,
  input  logic               id_mem_r_en,
  input  logic               flush,
  input  logic               mem_stall,
  input  logic               cnt_clr,
  output logic               hazard,
  output logic [SW-1:0]      fwd_sel1,
  output logic [SW-1:0]      fwd_sel2,
  output logic [15:0]        stall_cnt
);

  sb_slot_t [DEPTH-1:0] slots_q, slots_d;
  logic     [15:0]      stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] match1, match2;
  logic             load_hit1, load_hit2;
  sb_sel_t          sel1, sel2;
  logic             dep_hazard;

  sb_src_match #(.DEPTH(DEPTH)) u_src1_match (
    .src_en   (id_src1_en),
    .src      (sb_dest_t'(id_src1)),
    .slots    (slots_q),
    .match    (match1),
    .load_hit (load_hit1),
    .sel      (sel1)
  );

  sb_src_match #(.DEPTH(DEPTH)) u_src2_match (
    .src_en   (id_src2_en),
    .src      (sb_dest_t'(id_src2)),
    .slots    (slots_q),
    .match    (match2),
    .load_hit (load_hit2),
    .sel      (sel2)
  );

  always_comb begin
    dep_hazard = 1'b0;
    hazard     = 1'b0;
    fwd_sel1   = '0;
    fwd_sel2   = '0;
    if (FWD_EN != 0) begin
      dep_hazard = id_valid & (load_hit1 | load_hit2);
    end else begin
      dep_hazard = id_valid & ((|match1) | (|match2));
    end
    if (rst) begin
      hazard = dep_hazard | mem_stall;
      if (FWD_EN != 0) begin
        fwd_sel1 = SW'(sel1);
        fwd_sel2 = SW'(sel2);
      end
    end
  end

  always_comb begin
    slots_d = slots_q;
    if (!mem_stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0] = '0;
      if (id_valid && !hazard && !flush) begin
        slots_d[0].valid   = 1'b1;
        slots_d[0].wb_en   = id_wb_en;
        slots_d[0].dest    = sb_dest_t'(id_dest);
        slots_d[0].is_load = id_mem_r_en;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (hazard && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a forwarding instance and a stall-only instance share the
// ID-stage stimulus; expected values are hand-computed per cycle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_src1_en, id_src2_en, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       flush, mem_stall, cnt_clr;

  logic       hz_f, hz_s;
  logic [1:0] f1_f, f2_f, f1_s, f2_s;
  logic [15:0] cnt_f, cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG_AW(4), .DEPTH(3), .FWD_EN(1)) dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en),
    .flush(flush), .mem_stall(mem_stall), .cnt_clr(cnt_clr),
    .hazard(hz_f), .fwd_sel1(f1_f), .fwd_sel2(f2_f), .stall_cnt(cnt_f)
  );

  hazard_scoreboard #(.NREG_AW(4), .DEPTH(3), .FWD_EN(0)) dut_stl (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en),
    .flush(flush), .mem_stall(mem_stall), .cnt_clr(cnt_clr),
    .hazard(hz_s), .fwd_sel1(f1_s), .fwd_sel2(f2_s), .stall_cnt(cnt_s)
  );

  typedef struct {
    logic       v, s1e;
    logic [3:0] s1;
    logic       s2e;
    logic [3:0] s2;
    logic       wb;
    logic [3:0] d;
    logic       ld, fl, ms, clr;
    logic       hz;
    logic [1:0] f1, f2;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(bit v, bit s1e, int s1, bit s2e, int s2, bit wb,
                              int d, bit ld, bit fl, bit ms, bit clr,
                              bit hz, int f1, int f2, int cnt);
    vec_t r;
    r.v = v; r.s1e = s1e; r.s1 = 4'(s1); r.s2e = s2e; r.s2 = 4'(s2);
    r.wb = wb; r.d = 4'(d); r.ld = ld; r.fl = fl; r.ms = ms; r.clr = clr;
    r.hz = hz; r.f1 = 2'(f1); r.f2 = 2'(f2); r.cnt = 16'(cnt);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit s1e, input int s1, input bit s2e,
                        input int s2, input bit wb, input int d, input bit ld,
                        input bit fl, input bit ms, input bit clr);
    id_valid = v; id_src1_en = s1e; id_src1 = 4'(s1);
    id_src2_en = s2e; id_src2 = 4'(s2); id_wb_en = wb; id_dest = 4'(d);
    id_mem_r_en = ld; flush = fl; mem_stall = ms; cnt_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    //            v s1e s1 s2e s2 wb d ld fl ms clr  hz f1 f2 cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,  0, 0, 0, 0); // load r3
    vecs[1]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0); // load-use
    vecs[2]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 0, 1); // alu r5
    vecs[4]  = mk(1, 0, 5, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    vecs[5]  = mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1);
    vecs[6]  = mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1); // r5 in WB
    vecs[7]  = mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0,  0, 0, 0, 1);
    vecs[8]  = mk(1, 1, 6, 0, 0, 1, 6, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[9]  = mk(1, 1, 6, 1, 6, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1); // youngest wins
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0,  0, 0, 0, 1); // flushed r7
    vecs[11] = mk(1, 1, 7, 1, 6, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0,  0, 0, 0, 1); // load r8
    vecs[13] = mk(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1); // no id_valid
    vecs[14] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0,  0, 0, 0, 1); // load r9
    vecs[15] = mk(1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1); // flush+hazard
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 2); // clr wins
    vecs[17] = mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0);

    rst = 1'b0;
    set_in(1, 1, 3, 0, 0, 1, 3, 1, 0, 1, 0);
    tick();
    tick();
    #4;
    chk("rst_hazard", 32'(hz_f), 32'd0);
    chk("rst_hazard_stall_mode", 32'(hz_s), 32'd0);
    chk("rst_cnt", 32'(cnt_f), 32'd0);
    chk("rst_sel1", 32'(f1_f), 32'd0);
    tick();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].v, vecs[i].s1e, int'(vecs[i].s1), vecs[i].s2e, int'(vecs[i].s2),
             vecs[i].wb, int'(vecs[i].d), vecs[i].ld, vecs[i].fl, vecs[i].ms, vecs[i].clr);
      #4;
      chk($sformatf("v%0d_hazard", i), 32'(hz_f), 32'(vecs[i].hz));
      chk($sformatf("v%0d_sel1", i), 32'(f1_f), 32'(vecs[i].f1));
      chk($sformatf("v%0d_sel2", i), 32'(f2_f), 32'(vecs[i].f2));
      chk($sformatf("v%0d_cnt", i), 32'(cnt_f), 32'(vecs[i].cnt));
      tick();
    end

    // Memory stall with a load in slot 0: slots freeze, flush is dropped.
    set_in(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 3, 0, 0, 0, 0, 0, (i == 1), 1, 0);
      #4;
      chk($sformatf("mstall%0d_hazard", i), 32'(hz_f), 32'd1);
      chk($sformatf("mstall%0d_sel1", i), 32'(f1_f), 32'd1);
      tick();
    end
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("mstall_cnt", 32'(cnt_f), 32'd3);
    chk("mstall_frozen_hazard", 32'(hz_f), 32'd1);
    chk("mstall_frozen_sel1", 32'(f1_f), 32'd1);
    tick();
    #4;
    chk("mstall_after_hazard", 32'(hz_f), 32'd0);
    chk("mstall_after_sel1", 32'(f1_f), 32'd2);
    chk("mstall_after_cnt", 32'(cnt_f), 32'd4);
    tick();

    // Drain both pipelines, then compare stall-only and forwarding modes.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    #4;
    chk("so_write_hazard", 32'(hz_s), 32'd0);
    tick();
    set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("so_rd0_hazard", 32'(hz_s), 32'd1);
    chk("so_rd0_sel1", 32'(f1_s), 32'd0);
    chk("fw_rd0_hazard", 32'(hz_f), 32'd0);
    chk("fw_rd0_sel1", 32'(f1_f), 32'd1);
    tick();
    #4;
    chk("so_rd1_hazard", 32'(hz_s), 32'd1);
    chk("fw_rd1_sel1", 32'(f1_f), 32'd2);
    tick();
    #4;
    chk("so_rd2_hazard", 32'(hz_s), 32'd0);
    chk("so_rd2_sel1", 32'(f1_s), 32'd0);
    chk("fw_rd2_sel1", 32'(f1_f), 32'd0);
    tick();

    // Counter saturation, clear priority, and reset mid-run.
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (70000) tick();
    #4;
    chk("sat_cnt", 32'(cnt_f), 32'hFFFF);
    chk("sat_cnt_stall_mode", 32'(cnt_s), 32'hFFFF);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #4;
    chk("clr_hazard", 32'(hz_f), 32'd1);
    chk("sat_hold_cnt", 32'(cnt_f), 32'hFFFF);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("clr_cnt", 32'(cnt_f), 32'd0);
    tick();
    set_in(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    tick();
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    #4;
    chk("pre_rst_hazard", 32'(hz_f), 32'd1);
    tick();
    rst = 1'b0;
    #4;
    chk("in_rst_hazard", 32'(hz_f), 32'd0);
    chk("in_rst_sel1", 32'(f1_f), 32'd0);
    tick();
    #4;
    chk("in_rst_cnt", 32'(cnt_f), 32'd0);
    tick();
    rst = 1'b1;
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("post_rst_hazard", 32'(hz_f), 32'd0);
    chk("post_rst_sel1", 32'(f1_f), 32'd0);
    chk("post_rst_cnt", 32'(cnt_f), 32'd0);
    chk("post_rst_hazard_stall_mode", 32'(hz_s), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
